// File: rtl/universal_bin_counter_monitor_pkg.sv
// universal_bin_counter_monitor_pkg: FSM state encoding and counter command priority.
package universal_bin_counter_monitor_pkg;
    localparam logic MON_SYNC  = 1'b0;
    localparam logic MON_TRACK = 1'b1;
    typedef enum logic [2:0] {CMD_HOLD, CMD_UP, CMD_DOWN, CMD_LOAD, CMD_CLR} cmd_e;
    // Clear beats load beats counting, matching the monitored counter.
    function automatic cmd_e decode_cmd(input logic syn_clr, input logic load, input logic en, input logic up);
        return syn_clr ? CMD_CLR : load ? CMD_LOAD : !en ? CMD_HOLD : up ? CMD_UP : CMD_DOWN;
    endfunction
endpackage

// File: rtl/ubc_ref_next.sv
// ubc_ref_next: reference next-count of the universal binary counter from a given current value.
module ubc_ref_next
    import universal_bin_counter_monitor_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] cur,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    input  logic         syn_clr,
    input  logic         load,
    output logic [N-1:0] nxt
);
    cmd_e cmd;
    always_comb begin
        cmd = decode_cmd(syn_clr, load, en, up);
        nxt = (cmd == CMD_CLR)  ? '0 :
              (cmd == CMD_LOAD) ? d :
              (cmd == CMD_UP)   ? cur + N'(1) :
              (cmd == CMD_DOWN) ? cur - N'(1) : cur;
    end
endmodule

// File: rtl/universal_bin_counter_monitor.sv
// universal_bin_counter_monitor: shadow-count checker for universal_bin_counter.
// Define UBC_MON_REALIGN_EN to realign the shadow onto the observed count after a mismatch.
module universal_bin_counter_monitor
    import universal_bin_counter_monitor_pkg::*;
#(
    parameter int N     = 3,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             resync,
    input  logic             en,
    input  logic             up,
    input  logic [N-1:0]     d,
    input  logic             syn_clr,
    input  logic             load,
    input  logic [N-1:0]     q,
    input  logic             max_tick,
    input  logic             min_tick,
    output logic [N-1:0]     exp_q,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [N-1:0]     first_exp,
    output logic [N-1:0]     first_obs,
    output logic             tracking
);
`ifdef UBC_MON_REALIGN_EN
    localparam logic REALIGN = 1'b1;
`else
    localparam logic REALIGN = 1'b0;
`endif
    logic             state_q, state_d;
    logic [N-1:0]     exp_d, nxt_obs, nxt_exp, first_exp_q, first_exp_d, first_obs_q, first_obs_d;
    logic             err_q, err_d, sticky_q, sticky_d, mism;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    ubc_ref_next #(.N(N)) u_ref_obs (.cur(q), .en(en), .up(up), .d(d), .syn_clr(syn_clr), .load(load), .nxt(nxt_obs));
    ubc_ref_next #(.N(N)) u_ref_exp (.cur(exp_q), .en(en), .up(up), .d(d), .syn_clr(syn_clr), .load(load), .nxt(nxt_exp));

    always_comb begin
        state_d = resync ? MON_SYNC : MON_TRACK;
    end

    always_comb begin
        mism        = (state_q == MON_TRACK) &
                      ((q != exp_q) | (max_tick != (q == '1)) | (min_tick != (q == '0)));
        exp_d       = (state_q == MON_SYNC || (REALIGN && mism)) ? nxt_obs : nxt_exp;
        err_d       = mism;
        sticky_d    = sticky_q | mism;
        cnt_d       = (mism && cnt_q != '1) ? cnt_q + ERR_W'(1) : cnt_q;
        first_exp_d = (mism && !sticky_q) ? exp_q : first_exp_q;
        first_obs_d = (mism && !sticky_q) ? q : first_obs_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= MON_SYNC;
            exp_q       <= '0;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            first_exp_q <= '0;
            first_obs_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            first_exp_q <= first_exp_d;
            first_obs_q <= first_obs_d;
        end
    end

    always_comb begin
        err        = err_q;
        err_sticky = sticky_q;
        err_cnt    = cnt_q;
        first_exp  = first_exp_q;
        first_obs  = first_obs_q;
        tracking   = (state_q == MON_TRACK);
    end
endmodule

// File: tb/tb_universal_bin_counter_monitor.sv
// tb_universal_bin_counter_monitor: directed checks of the counter monitor against a behavioural counter.
module tb_universal_bin_counter_monitor;
`ifdef UBC_MON_REALIGN_EN
    localparam bit REALIGN = 1'b1;
`else
    localparam bit REALIGN = 1'b0;
`endif
    logic       clk = 1'b0, reset, resync, en, up, syn_clr, load, max_tick, min_tick, tick_inv;
    logic [2:0] d, q, cnt, ofs;
    logic [2:0] exp_q, first_exp, first_obs;
    logic       err, err_sticky, tracking;
    logic [7:0] err_cnt;
    int         total = 0, bad = 0;

    universal_bin_counter_monitor #(.N(3), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .resync(resync), .en(en), .up(up), .d(d),
        .syn_clr(syn_clr), .load(load), .q(q), .max_tick(max_tick), .min_tick(min_tick),
        .exp_q(exp_q), .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt),
        .first_exp(first_exp), .first_obs(first_obs), .tracking(tracking)
    );

    always #5 clk = ~clk;

    // Stand-in for the monitored counter; ofs and tick_inv inject faults into what the monitor sees.
    always @(posedge clk) begin
        if (!reset) cnt <= '0;
        else if (syn_clr) cnt <= '0;
        else if (load) cnt <= d;
        else if (en) cnt <= up ? cnt + 3'd1 : cnt - 3'd1;
    end
    assign q        = cnt + ofs;
    assign max_tick = (q == 3'd7) ^ tick_inv;
    assign min_tick = (q == 3'd0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_exp_q"}, 32'(exp_q), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_sticky"}, 32'(err_sticky), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
        chk({tag, "_first_exp"}, 32'(first_exp), 0);
        chk({tag, "_first_obs"}, 32'(first_obs), 0);
        chk({tag, "_tracking"}, 32'(tracking), 0);
    endtask

    initial begin
        reset = 0; resync = 0; en = 0; up = 0; syn_clr = 0; load = 0; d = '0; ofs = '0; tick_inv = 0;
        tick(); tick();
        chk_reset_state("rst");
        // held load of 2 while enabled
        reset = 1; load = 1; d = 3'd2; en = 1; up = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_exp_q", 32'(exp_q), 2);
            chk("t1_err", 32'(err), 0);
            chk("t1_tracking", 32'(tracking), 1);
        end
        chk("t1_err_cnt", 32'(err_cnt), 0);
        // clear then count up across the wrap
        load = 0; syn_clr = 1;
        tick();
        chk("t2_clr_exp_q", 32'(exp_q), 0);
        syn_clr = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("t2_exp_q", 32'(exp_q), i % 8);
            chk("t2_err", 32'(err), 0);
        end
        chk("t2_err_cnt", 32'(err_cnt), 0);
        // counter jumps from 3 to 5 and stays offset
        tick(); tick();
        chk("t3_exp_q_pre", 32'(exp_q), 3);
        en = 0; ofs = 3'd2;
        tick();
        chk("t3_err", 32'(err), 1);
        chk("t3_err_cnt", 32'(err_cnt), 1);
        chk("t3_sticky", 32'(err_sticky), 1);
        chk("t3_first_exp", 32'(first_exp), 3);
        chk("t3_first_obs", 32'(first_obs), 5);
        chk("t3_exp_q", 32'(exp_q), REALIGN ? 5 : 3);
        tick();
        chk("t3_err_again", 32'(err), REALIGN ? 0 : 1);
        chk("t3_err_cnt2", 32'(err_cnt), REALIGN ? 1 : 2);
        ofs = '0; resync = 1;
        tick();
        chk("t3_resync_err", 32'(err), REALIGN ? 1 : 0);
        chk("t3_resync_err_cnt", 32'(err_cnt), 2);
        chk("t3_resync_tracking", 32'(tracking), 0);
        chk("t3_first_obs_kept", 32'(first_obs), 5);
        resync = 0;
        tick();
        chk("t3_sync_tracking", 32'(tracking), 1);
        chk("t3_sync_exp_q", 32'(exp_q), 3);
        chk("t3_sync_err", 32'(err), 0);
        // clear wins over simultaneous load
        syn_clr = 1; load = 1; d = 3'd6; en = 1;
        tick();
        chk("t4_exp_q", 32'(exp_q), 0);
        syn_clr = 0; load = 0; en = 0;
        tick();
        chk("t4_err", 32'(err), 0);
        chk("t4_err_cnt", 32'(err_cnt), 2);
        // wrong max_tick every cycle saturates the error counter
        tick_inv = 1;
        repeat (300) tick();
        chk("t5_err_cnt", 32'(err_cnt), 255);
        chk("t5_sticky", 32'(err_sticky), 1);
        chk("t5_err", 32'(err), 1);
        chk("t5_first_exp", 32'(first_exp), 3);
        chk("t5_first_obs", 32'(first_obs), 5);
        tick_inv = 0;
        tick();
        chk("t5_err_clear", 32'(err), 0);
        chk("t5_err_cnt_hold", 32'(err_cnt), 255);
        // reset in the middle of a count
        en = 1; up = 1;
        repeat (4) tick();
        chk("t6_exp_q_pre", 32'(exp_q), 4);
        chk("t6_err_pre", 32'(err), 0);
        reset = 0;
        tick();
        chk_reset_state("t6_rst");
        reset = 1;
        tick();
        chk("t6_tracking", 32'(tracking), 1);
        chk("t6_exp_q1", 32'(exp_q), 1);
        tick();
        chk("t6_exp_q2", 32'(exp_q), 2);
        chk("t6_err", 32'(err), 0);
        chk("t6_sticky", 32'(err_sticky), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
